// File: rtl/prog_load_ctrl.sv
// prog_load_ctrl: boot/run sequencer in front of the single-cycle core.
// Streams host machine code into instruction memory while the core is held in
// reset, releases it after a short boot window, pulses req, then watches the
// core's done flag and reports done / timeout / run cycle count to the host.
module prog_load_ctrl #(
    parameter int D        = 12,
    parameter int W        = 9,
    parameter int BOOT_CYC = 2,
    parameter int TIMEOUT  = 4096,
    parameter int CW       = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [D-1:0]  load_len,
    input  logic          s_valid,
    input  logic [W-1:0]  s_data,
    output logic          s_ready,
    output logic          im_wr_en,
    output logic [D-1:0]  im_addr,
    output logic [W-1:0]  im_dat,
    output logic          core_rst,
    output logic          core_req,
    input  logic          core_done,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [CW-1:0] cycles
);

    typedef enum logic [2:0] {IDLE, LOAD, BOOT, RUN, FIN} state_t;

    localparam int BW = (BOOT_CYC > 1) ? $clog2(BOOT_CYC) : 1;

    state_t        state_q, state_d;
    logic [D-1:0]  wcnt_q, wcnt_d;
    logic [D-1:0]  len_q, len_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic          done_q, done_d;
    logic          to_q, to_d;
    logic          wr_en_q, wr_en_d;
    logic [D-1:0]  wr_addr_q, wr_addr_d;
    logic [W-1:0]  wr_dat_q, wr_dat_d;

    // State and datapath registers; reset drops straight back to IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            wcnt_q    <= '0;
            len_q     <= '0;
            bcnt_q    <= '0;
            cyc_q     <= '0;
            done_q    <= 1'b0;
            to_q      <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_dat_q  <= '0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            len_q     <= len_d;
            bcnt_q    <= bcnt_d;
            cyc_q     <= cyc_d;
            done_q    <= done_d;
            to_q      <= to_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_dat_q  <= wr_dat_d;
        end
    end

    // Next-state logic: sequencing, registered memory write, run accounting.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        len_d     = len_q;
        bcnt_d    = bcnt_q;
        cyc_d     = cyc_q;
        done_d    = done_q;
        to_d      = to_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_dat_d  = wr_dat_q;
        case (state_q)
            IDLE, FIN: begin
                if (start) begin
                    done_d  = 1'b0;
                    to_d    = 1'b0;
                    cyc_d   = '0;
                    wcnt_d  = '0;
                    bcnt_d  = '0;
                    len_d   = load_len;
                    state_d = (load_len != '0) ? LOAD : BOOT;
                end
            end
            LOAD: begin
                // s_ready is high for the whole state, so s_valid is the handshake
                if (s_valid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = wcnt_q;
                    wr_dat_d  = s_data;
                    wcnt_d    = wcnt_q + 1'b1;
                    if (wcnt_q == len_q - 1'b1) begin
                        bcnt_d  = '0;
                        state_d = BOOT;
                    end
                end
            end
            BOOT: begin
                if (bcnt_q == BW'(BOOT_CYC - 1)) state_d = RUN;
                else                             bcnt_d  = bcnt_q + 1'b1;
            end
            RUN: begin
                cyc_d = cyc_q + 1'b1;
                // done has priority over a coincident timeout
                if (core_done) begin
                    done_d  = 1'b1;
                    state_d = FIN;
                end else if (cyc_q == CW'(TIMEOUT - 1)) begin
                    to_d    = 1'b1;
                    state_d = FIN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign s_ready  = (state_q == LOAD);
    assign busy     = (state_q == LOAD) || (state_q == BOOT) || (state_q == RUN);
    assign core_rst = (state_q != RUN);
    // cycle count is still zero only in the first RUN cycle
    assign core_req = (state_q == RUN) && (cyc_q == '0);
    assign im_wr_en = wr_en_q;
    assign im_addr  = wr_addr_q;
    assign im_dat   = wr_dat_q;
    assign done     = done_q;
    assign timeout  = to_q;
    assign cycles   = cyc_q;

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Bench for prog_load_ctrl: vector table for a basic load/run, hand sequences
// for reset/back-pressure/timeout, and randomized runs scored against a
// transaction-level expectation (write list, req timing, final flags).
module tb_prog_load_ctrl;
    localparam int D = 12, W = 9, BOOT = 2, TOA = 16, TOB = 8, CW = 16;

    logic          clk = 1'b0, reset = 1'b0, start = 1'b0, s_valid = 1'b0, core_done = 1'b0;
    logic [D-1:0]  load_len = '0;
    logic [W-1:0]  s_data = '0;

    logic          s_ready, im_wr_en, core_rst, core_req, busy, done, timeout;
    logic [D-1:0]  im_addr;
    logic [W-1:0]  im_dat;
    logic [CW-1:0] cycles;

    logic          s_ready_b, im_wr_en_b, core_rst_b, core_req_b, busy_b, done_b, timeout_b;
    logic [D-1:0]  im_addr_b;
    logic [W-1:0]  im_dat_b;
    logic [CW-1:0] cycles_b;

    always #5 clk = ~clk;

    prog_load_ctrl #(.D(D), .W(W), .BOOT_CYC(BOOT), .TIMEOUT(TOA), .CW(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .load_len(load_len),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .im_wr_en(im_wr_en), .im_addr(im_addr), .im_dat(im_dat),
        .core_rst(core_rst), .core_req(core_req), .core_done(core_done),
        .busy(busy), .done(done), .timeout(timeout), .cycles(cycles));

    // Short-timeout instance, only checked in the timeout sequences
    prog_load_ctrl #(.D(D), .W(W), .BOOT_CYC(BOOT), .TIMEOUT(TOB), .CW(CW)) dut_b (
        .clk(clk), .reset(reset), .start(start), .load_len(load_len),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready_b),
        .im_wr_en(im_wr_en_b), .im_addr(im_addr_b), .im_dat(im_dat_b),
        .core_rst(core_rst_b), .core_req(core_req_b), .core_done(core_done),
        .busy(busy_b), .done(done_b), .timeout(timeout_b), .cycles(cycles_b));

    int checks = 0, failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: samples mid-low-phase, logs handshakes, writes and req pulses
    typedef struct { int c; logic [D-1:0] a; logic [W-1:0] d; } wr_t;
    wr_t wrq[$];
    int  hsq[$];
    int  reqq[$];
    int  cyc = 0;

    always @(negedge clk) begin
        #2;
        cyc++;
        if (reset) begin
            if (s_valid && s_ready) hsq.push_back(cyc);
            if (im_wr_en) wrq.push_back('{cyc, im_addr, im_dat});
            if (core_req) reqq.push_back(cyc);
        end
    end

    // Vector table row: inputs then expected outputs for the same cycle
    typedef struct packed {
        logic st; logic [D-1:0] len; logic sv; logic [W-1:0] sd; logic cd;
        logic rdy; logic we; logic [D-1:0] ad; logic [W-1:0] dt;
        logic rst; logic req; logic bsy; logic dn; logic to;
        logic [CW-1:0] cy; logic cychk;
    } vec_t;
    vec_t tbl[11];

    // Full load+run sequence on the main instance, scored against the rules
    task automatic run_seq(input int len, input int k, input bit use_pat,
                           input logic [31:0] vpat, input bit noise, input string nm);
        logic [W-1:0] words[$];
        int idx = 0, lc = 0, run_n = 0, n = 0, start_c, last_c, exp_cyc;
        bit fin = 0, exp_done;
        for (int i = 0; i < len; i++) words.push_back(W'($urandom));
        wrq.delete(); hsq.delete(); reqq.delete();
        @(negedge clk);
        start = 1'b1; load_len = D'(len); s_valid = 1'b0; core_done = 1'b0;
        #1;
        start_c = cyc + 1;
        while (!fin && n < 400) begin
            @(negedge clk);
            n++;
            start = noise && !core_rst && ($urandom_range(0, 3) == 0);
            if (noise) load_len = D'($urandom);
            if (s_ready) begin
                s_valid = use_pat ? vpat[lc % 32] : ($urandom_range(0, 2) != 0);
                lc++;
                s_data = (s_valid && idx < len) ? words[idx] : W'($urandom);
                if (s_valid) idx++;
            end else begin
                s_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                s_data  = W'($urandom);
            end
            if (!core_rst) begin
                run_n++;
                core_done = (run_n == k);
            end else begin
                core_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            #1;
            if (n == 1)
                chk({nm, "_cleared"}, {busy, done, timeout, cycles}, {1'b1, 1'b0, 1'b0, CW'(0)});
            if (!busy) fin = 1;
        end
        chk({nm, "_finished"}, 64'(fin), 64'd1);
        exp_done = (k <= TOA);
        exp_cyc  = exp_done ? k : TOA;
        chk({nm, "_done"}, 64'(done), 64'(exp_done));
        chk({nm, "_timeout"}, 64'(timeout), 64'(!exp_done));
        chk({nm, "_cycles"}, 64'(cycles), 64'(exp_cyc));
        chk({nm, "_run_cycles"}, 64'(run_n), 64'(exp_cyc));
        // FIN must ignore core_done and start stays low
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'b0; s_valid = 1'b0; core_done = ~core_done;
        end
        #1;
        chk({nm, "_hold"}, {core_rst, busy, done, timeout, cycles},
            {1'b1, 1'b0, exp_done, !exp_done, CW'(exp_cyc)});
        chk({nm, "_nwr"}, 64'(wrq.size()), 64'(len));
        chk({nm, "_nhs"}, 64'(hsq.size()), 64'(len));
        for (int i = 0; i < len && i < wrq.size() && i < hsq.size(); i++) begin
            chk({nm, "_wr_addr"}, 64'(wrq[i].a), 64'(i));
            chk({nm, "_wr_dat"}, 64'(wrq[i].d), 64'(words[i]));
            chk({nm, "_wr_lat"}, 64'(wrq[i].c), 64'(hsq[i] + 1));
        end
        chk({nm, "_nreq"}, 64'(reqq.size()), 64'd1);
        if (reqq.size() > 0) begin
            last_c = (len > 0 && hsq.size() >= len) ? hsq[len-1] : start_c;
            chk({nm, "_req_time"}, 64'(reqq[0]), 64'(last_c + BOOT + 1));
        end
    endtask

    // Timeout-instance sequence: len 0, core_done optionally on RUN cycle dk
    task automatic run_b(input int dk, input string nm);
        int n = 0, run = 0;
        @(negedge clk);
        start = 1'b1; load_len = '0; s_valid = 1'b0; core_done = 1'b0;
        do begin
            @(negedge clk);
            start = 1'b0;
            n++;
            if (!core_rst_b) run++;
            core_done = !core_rst_b && (run == dk);
            #1;
        end while ((busy_b || n < 2) && n < 100);
        chk({nm, "_bound"}, 64'(n < 100), 64'd1);
        chk({nm, "_run_cycles"}, 64'(run), 64'(TOB));
        chk({nm, "_flags"}, {done_b, timeout_b, core_rst_b, busy_b},
            {dk == TOB, dk != TOB, 1'b1, 1'b0});
        chk({nm, "_cycles"}, 64'(cycles_b), 64'(TOB));
    endtask

    initial begin
        //          st len    sv sd      cd  rdy we ad  dt      rst req bsy dn to cy chk
        tbl[0]  = '{1, 12'd3, 0, 9'h000, 0,  0, 0, 12'd0, 9'h000, 1, 0, 0, 0, 0, 16'd0, 1};
        tbl[1]  = '{0, 12'd3, 1, 9'h1A3, 0,  1, 0, 12'd0, 9'h000, 1, 0, 1, 0, 0, 16'd0, 1};
        tbl[2]  = '{0, 12'd0, 1, 9'h005, 0,  1, 1, 12'd0, 9'h1A3, 1, 0, 1, 0, 0, 16'd0, 1};
        tbl[3]  = '{0, 12'd7, 1, 9'h1FF, 0,  1, 1, 12'd1, 9'h005, 1, 0, 1, 0, 0, 16'd0, 1};
        tbl[4]  = '{0, 12'd7, 1, 9'h0AA, 0,  0, 1, 12'd2, 9'h1FF, 1, 0, 1, 0, 0, 16'd0, 1};
        tbl[5]  = '{0, 12'd7, 0, 9'h000, 0,  0, 0, 12'd2, 9'h1FF, 1, 0, 1, 0, 0, 16'd0, 1};
        tbl[6]  = '{0, 12'd7, 0, 9'h000, 0,  0, 0, 12'd2, 9'h1FF, 0, 1, 1, 0, 0, 16'd0, 0};
        tbl[7]  = '{0, 12'd7, 0, 9'h000, 1,  0, 0, 12'd2, 9'h1FF, 0, 0, 1, 0, 0, 16'd0, 0};
        tbl[8]  = '{0, 12'd7, 0, 9'h000, 0,  0, 0, 12'd2, 9'h1FF, 1, 0, 0, 1, 0, 16'd2, 1};
        tbl[9]  = '{0, 12'd7, 0, 9'h000, 1,  0, 0, 12'd2, 9'h1FF, 1, 0, 0, 1, 0, 16'd2, 1};
        tbl[10] = '{0, 12'd7, 1, 9'h000, 0,  0, 0, 12'd2, 9'h1FF, 1, 0, 0, 1, 0, 16'd2, 1};

        // Reset state
        @(negedge clk); #1;
        chk("reset_core_rst", 64'(core_rst), 64'd1);
        chk("reset_outputs", {s_ready, im_wr_en, im_addr, im_dat, core_req, busy, done, timeout, cycles}, '0);
        @(negedge clk);
        reset = 1'b1;

        // Basic load/run from the vector table
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            start = tbl[i].st; load_len = tbl[i].len; s_valid = tbl[i].sv;
            s_data = tbl[i].sd; core_done = tbl[i].cd;
            #1;
            chk($sformatf("vec%0d_outs", i),
                {s_ready, im_wr_en, im_addr, im_dat, core_rst, core_req, busy, done, timeout},
                {tbl[i].rdy, tbl[i].we, tbl[i].ad, tbl[i].dt, tbl[i].rst, tbl[i].req,
                 tbl[i].bsy, tbl[i].dn, tbl[i].to});
            if (tbl[i].cychk) chk($sformatf("vec%0d_cycles", i), 64'(cycles), 64'(tbl[i].cy));
        end

        // Reset mid-LOAD after word 2 of 5
        @(negedge clk);
        start = 1'b1; load_len = 12'd5; s_valid = 1'b0; core_done = 1'b0;
        @(negedge clk); start = 1'b0; s_valid = 1'b1; s_data = 9'h011;
        @(negedge clk); s_data = 9'h022;
        @(negedge clk); s_data = 9'h033;
        #1;
        chk("midload_pre_wr", {im_wr_en, im_addr, im_dat, busy}, {1'b1, 12'd1, 9'h022, 1'b1});
        reset = 1'b0;
        #1;
        chk("midload_abort", {core_rst, s_ready, busy, im_wr_en, im_addr, im_dat},
            {1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 9'h000});
        s_valid = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); #1;
        chk("midload_idle", {core_rst, s_ready, busy, im_wr_en}, {1'b1, 1'b0, 1'b0, 1'b0});

        // Back-pressure gaps, normal finish at cycle 10, zero-length load
        run_seq(3, 4, 1'b1, 32'b11001, 1'b0, "gaps");
        run_seq(2, 10, 1'b0, 32'h0, 1'b0, "finish10");
        run_seq(0, 3, 1'b0, 32'h0, 1'b0, "len0");
        run_seq(2, 40, 1'b0, 32'h0, 1'b0, "timeout_a");

        // Randomized runs: random length, gaps, done point, noise on inputs
        for (int t = 0; t < 20; t++)
            run_seq($urandom_range(0, 6), $urandom_range(1, 20), 1'b0, 32'h0, 1'b1,
                    $sformatf("rnd%0d", t));

        // Timeout instance: pure timeout, then done landing on the last cycle
        @(negedge clk); reset = 1'b0; start = 1'b0; s_valid = 1'b0; core_done = 1'b0;
        @(negedge clk); reset = 1'b1;
        run_b(0, "to8");
        run_b(TOB, "to8_done_wins");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prog_load_ctrl.md
Name: prog_load_ctrl

Overview:
- Boot/run sequencer that sits directly upstream of the single-cycle core top level.
- Streams 9-bit machine code words from a host into the instruction memory write port.
- Holds the core in reset while loading, then releases it and issues the req pulse.
- Watches the core's done flag and reports completion, timeout and the run cycle count back to the host.

Parameters:
D, 12, program counter / instruction memory address width
W, 9, machine code word width
BOOT_CYC, 2, cycles core_rst stays high after load before release (>=1)
TIMEOUT, 4096, max RUN cycles before abort (>=2)
CW, 16, cycle counter width; must satisfy 2^CW > TIMEOUT

Ports:
clk  in  1  clock, all state on posedge
reset  in  1  asynchronous, active-low; 0 forces reset state immediately
start  in  1  one-cycle request to begin a load+run sequence
load_len  in  D  number of words to load; sampled on accepted start
s_valid  in  1  host word valid
s_data  in  W  host machine code word
s_ready  out  1  block accepts word this cycle
im_wr_en  out  1  instruction memory write enable
im_addr  out  D  instruction memory write address
im_dat  out  W  instruction memory write data
core_rst  out  1  active-high reset to core
core_req  out  1  one-cycle start pulse to core
core_done  in  1  core done flag
busy  out  1  sequence in progress
done  out  1  sticky: core finished normally
timeout  out  1  sticky: TIMEOUT reached without core_done
cycles  out  CW  RUN cycles counted in last/current run

Behaviour:
- Reset values:
  - state=IDLE, core_rst=1, all other outputs 0 (im_addr=0, im_dat=0, cycles=0).
  - Reset asserted mid-operation aborts at once to these values; the partial load is abandoned.
- State encoding: IDLE, LOAD, BOOT, RUN, FIN.
- Output decode:
  - s_ready = (state==LOAD), combinational from state.
  - busy = state in {LOAD, BOOT, RUN}.
  - core_rst = 1 in all states except RUN.
- Start acceptance and sequencing:
  - start is accepted only in IDLE or FIN.
  - On an accepted start: clear done, timeout, cycles and word counter wcnt. Next state is LOAD if load_len!=0, else BOOT.
  - start is ignored while busy.
- LOAD:
  - Handshake: s_valid&&s_ready.
  - The write is registered: the cycle after a handshake, im_wr_en=1, im_addr=wcnt, im_dat=s_data (captured at the handshake).
  - wcnt increments on each handshake.
  - On the handshake where wcnt==load_len-1, go to BOOT. s_ready drops the next cycle; the final write still occurs in the first BOOT cycle.
  - im_wr_en is 0 in any cycle that does not follow a handshake.
  - Addresses are always 0..load_len-1 with no wrap; load_len is latched at start, so later changes to the input have no effect.
- BOOT: stay BOOT_CYC cycles with core_rst=1, then go to RUN.
- RUN:
  - core_rst=0, and core_req=1 in the first RUN cycle only.
  - cycles increments every RUN cycle, starting at 1 in the first RUN cycle.
  - If core_done=1 in a RUN cycle, go to FIN with done=1 next cycle.
  - Else, if cycles==TIMEOUT-1 while incrementing, go to FIN with timeout=1 and cycles=TIMEOUT.
  - If core_done and the timeout condition occur in the same cycle, done wins: done=1, timeout=0.
- FIN:
  - core_rst=1 to freeze the core.
  - done/timeout/cycles hold until the next accepted start or reset.
  - core_done is ignored outside RUN.
- done and timeout are mutually exclusive at all times.

Test Plan:
- Reset mid-LOAD: drive reset=0 after word 2 of 5 -> same cycle core_rst=1, s_ready=0, busy=0, im_wr_en=0; after release, state is IDLE.
- Basic load:
  - Stimulus: start, load_len=3, words 0x1A3/0x005/0x1FF each with s_valid=1.
  - Required: writes (addr0,0x1A3), (1,0x005), (2,0x1FF), each one cycle after its handshake.
  - Then BOOT for 2 cycles, then core_req pulses once and core_rst=0.
- Back-pressure gaps: s_valid toggled 1,0,0,1,1 with load_len=3 -> exactly 3 writes, addresses 0..2, no write in gap cycles.
- Normal finish: core_done rises on RUN cycle 10 -> done=1, timeout=0, cycles=10, busy=0, core_rst=1; a later core_done toggle has no effect.
- Timeout with TIMEOUT=8 and core_done held 0:
  - Required: timeout=1, done=0, cycles=8 after 8 RUN cycles.
  - Variant: core_done=1 on cycle 8 -> done=1, timeout=0.
- Edge cases:
  - load_len=0 -> no writes, IDLE->BOOT->RUN directly.
  - start pulsed during RUN -> ignored.
  - start in FIN -> flags and cycles cleared, new sequence starts.
